tx_mode_sequencer: RTL and testbench

//  Schedules the operating mode of the transmit core (TxCore). Holds a small programmable table of
//  {ctrl, dwell} entries, steps through it driving io_ctrl, and inserts a muted guard gap at every mode

---
 rtl/tx_pkg.sv | 24 ++
 rtl/tx_mode_table.sv | 28 ++
 rtl/tx_mode_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_tx_mode_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit mode sequencer.
package tx_pkg;

    localparam int CTRL_W        = 4;
    localparam int DWELL_W       = 16;
    localparam int TX_DEPTH      = 8;
    localparam int GUARD_DEFAULT = 4;

    typedef logic [CTRL_W-1:0] tx_ctrl_t;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_GUARD,
        SEQ_RUN,
        SEQ_DONE
    } seq_state_e;

    typedef struct packed {
        tx_ctrl_t           ctrl;
        logic [DWELL_W-1:0] dwell;
    } mode_entry_t;

endpackage

// File: rtl/tx_mode_table.sv
// Mode schedule storage: one write port from the config side, one
// combinational read port for the sequencer. Contents are never reset.
module tx_mode_table
    import tx_pkg::*;
#(
    parameter int DEPTH = TX_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  mode_entry_t      wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output mode_entry_t      rd_data
);

    mode_entry_t mem [DEPTH];

    // Table write on an accepted config transfer.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/tx_mode_sequencer.sv
// Steps through the programmable mode table, driving the TxCore mode word
// and muting the output for a guard gap whenever the mode changes.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// SEQ_IDLE   | muted, config writes accepted, waiting for start
// SEQ_LOAD   | look up entry[cur_index]; zero-dwell entries are skipped here
// SEQ_GUARD  | muted gap after a mode change (or abort, then back to IDLE)
// SEQ_RUN    | unmuted for dwell cycles; next entry is looked up on expiry
// SEQ_DONE   | one-cycle done pulse, then IDLE
//
// The lookup of the following entry is folded into the last RUN cycle so
// back-to-back entries cost no extra cycle; only skipped entries spend a
// cycle in LOAD.
module tx_mode_sequencer
    import tx_pkg::*;
#(
    parameter int DEPTH = TX_DEPTH,
    parameter int GUARD = GUARD_DEFAULT,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int NUM_W = IDX_W + 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [CTRL_W-1:0]  cfg_ctrl,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [NUM_W-1:0]   num_entries,
    input  logic               loop_en,
    input  logic               start,
    input  logic               abort,
    output logic [CTRL_W-1:0]  io_ctrl,
    output logic               mute,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   cur_index
);

    localparam logic [DWELL_W-1:0] GUARD_LOAD = DWELL_W'(GUARD - 1);
    localparam logic [DWELL_W-1:0] CNT_ONE    = DWELL_W'(1);
    localparam logic [NUM_W-1:0]   NUM_ONE    = NUM_W'(1);
    localparam logic [NUM_W-1:0]   NUM_MAX    = NUM_W'(DEPTH);

    seq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    tx_ctrl_t           ctrl_q, ctrl_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic               loop_q, loop_d;
    logic               ran_q, ran_d;
    logic               aborting_q, aborting_d;
    logic               enter_entry;

    logic [NUM_W-1:0]   nxt, nxt2;
    logic               at_end, at_end2;
    logic [IDX_W-1:0]   nxt_idx, nxt2_idx, rd_addr;
    mode_entry_t        rd_entry, wr_entry;

    // Index arithmetic: one step ahead for RUN expiry, two for skipping a zero entry.
    assign nxt      = {1'b0, idx_q} + NUM_ONE;
    assign at_end   = (nxt == num_q);
    assign nxt_idx  = at_end ? '0 : nxt[IDX_W-1:0];
    assign nxt2     = {1'b0, nxt_idx} + NUM_ONE;
    assign at_end2  = (nxt2 == num_q);
    assign nxt2_idx = at_end2 ? '0 : nxt2[IDX_W-1:0];
    assign rd_addr  = (state_q == SEQ_RUN) ? nxt_idx : idx_q;

    assign wr_entry.ctrl  = cfg_ctrl;
    assign wr_entry.dwell = cfg_dwell;

    tx_mode_table #(.DEPTH(DEPTH)) u_table (
        .clock   (clock),
        .wr_en   (cfg_valid && cfg_ready),
        .wr_addr (cfg_addr),
        .wr_data (wr_entry),
        .rd_addr (rd_addr),
        .rd_data (rd_entry)
    );

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SEQ_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            ctrl_q     <= '0;
            num_q      <= '0;
            loop_q     <= 1'b0;
            ran_q      <= 1'b0;
            aborting_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            ctrl_q     <= ctrl_d;
            num_q      <= num_d;
            loop_q     <= loop_d;
            ran_q      <= ran_d;
            aborting_q <= aborting_d;
        end
    end

    // Next-state, index and shared guard/dwell counter logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        num_d       = num_q;
        loop_d      = loop_q;
        ran_d       = ran_q;
        aborting_d  = aborting_q;
        enter_entry = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (start && !abort) begin
                    num_d      = (num_entries > NUM_MAX) ? NUM_MAX : num_entries;
                    loop_d     = loop_en;
                    idx_d      = '0;
                    ran_d      = 1'b0;
                    aborting_d = 1'b0;
                    state_d    = (num_entries == '0) ? SEQ_DONE : SEQ_LOAD;
                end
            end
            SEQ_LOAD: begin
                if (rd_entry.dwell == '0) begin
                    if (at_end) begin
                        // A wrap is only allowed if this pass ran something.
                        if (loop_q && ran_q) begin
                            idx_d = '0;
                            ran_d = 1'b0;
                        end else begin
                            state_d = SEQ_DONE;
                        end
                    end else begin
                        idx_d = nxt_idx;
                    end
                end else begin
                    enter_entry = 1'b1;
                end
            end
            SEQ_GUARD: begin
                if (cnt_q == '0) begin
                    if (aborting_q) begin
                        state_d    = SEQ_IDLE;
                        aborting_d = 1'b0;
                    end else begin
                        state_d = SEQ_RUN;
                        cnt_d   = rd_entry.dwell - CNT_ONE;
                        ran_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SEQ_RUN: begin
                if (cnt_q == '0) begin
                    if (at_end && !loop_q) begin
                        state_d = SEQ_DONE;
                    end else begin
                        idx_d = nxt_idx;
                        if (at_end) begin
                            ran_d = 1'b0;
                        end
                        if (rd_entry.dwell != '0) begin
                            enter_entry = 1'b1;
                        end else if (at_end2 && !loop_q) begin
                            state_d = SEQ_DONE;
                        end else begin
                            idx_d   = nxt2_idx;
                            state_d = SEQ_LOAD;
                            if (at_end2) begin
                                ran_d = 1'b0;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        if (enter_entry) begin
            if (rd_entry.ctrl != ctrl_q) begin
                state_d = SEQ_GUARD;
                ctrl_d  = rd_entry.ctrl;
                cnt_d   = GUARD_LOAD;
            end else begin
                state_d = SEQ_RUN;
                cnt_d   = rd_entry.dwell - CNT_ONE;
                ran_d   = 1'b1;
            end
        end

        // An abort already in progress is left to finish its guard gap.
        if (abort && (state_q != SEQ_IDLE) && !aborting_q) begin
            state_d    = SEQ_GUARD;
            ctrl_d     = '0;
            cnt_d      = GUARD_LOAD;
            aborting_d = 1'b1;
        end
    end

    assign cfg_ready = (state_q == SEQ_IDLE);
    assign busy      = (state_q != SEQ_IDLE);
    assign mute      = (state_q != SEQ_RUN);
    assign done      = (state_q == SEQ_DONE);
    assign io_ctrl   = ctrl_q;
    assign cur_index = idx_q;

endmodule

// File: tb/tb_tx_mode_sequencer.sv
// Directed bench for tx_mode_sequencer: per-scenario checkpoint tables
// keyed by cycles after the start edge, plus hand-written corner cases.
module tb_tx_mode_sequencer;

    logic        clock;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [3:0]  cfg_ctrl;
    logic [15:0] cfg_dwell;
    logic [3:0]  num_entries;
    logic        loop_en;
    logic        start;
    logic        abort;
    logic [3:0]  io_ctrl;
    logic        mute;
    logic        busy;
    logic        done;
    logic [2:0]  cur_index;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int         scen;
        int         k;
        logic [3:0] ctrl;
        logic       mute;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } vec_t;

    vec_t vecs[$];

    int unm[16];
    int done_cnt;
    int rise_cnt;
    int c2_cnt;
    logic prev_mute;

    tx_mode_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_addr    (cfg_addr),
        .cfg_ctrl    (cfg_ctrl),
        .cfg_dwell   (cfg_dwell),
        .num_entries (num_entries),
        .loop_en     (loop_en),
        .start       (start),
        .abort       (abort),
        .io_ctrl     (io_ctrl),
        .mute        (mute),
        .busy        (busy),
        .done        (done),
        .cur_index   (cur_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input int s, input int k, input logic [3:0] c, input logic m,
                       input logic b, input logic d, input logic [2:0] i);
        vec_t v;
        v.scen = s; v.k = k; v.ctrl = c; v.mute = m; v.busy = b; v.done = d; v.idx = i;
        vecs.push_back(v);
    endtask

    task automatic write_entry(input int a, input int c, input int dw);
        cfg_valid = 1'b1;
        cfg_addr  = 3'(a);
        cfg_ctrl  = 4'(c);
        cfg_dwell = 16'(dw);
        @(negedge clock);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start(input int n, input logic lp);
        start       = 1'b1;
        num_entries = 4'(n);
        loop_en     = lp;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Walks k = 0..kmax (k = 0 is the cycle after the start edge), checking
    // every table record for this scenario and gathering output statistics.
    task automatic run_vectors(input int s, input int kmax, input int abort_k, input int poke_k);
        done_cnt  = 0;
        rise_cnt  = 0;
        c2_cnt    = 0;
        prev_mute = 1'b1;
        for (int i = 0; i < 16; i++) unm[i] = 0;
        for (int k = 0; k <= kmax; k++) begin
            if (k > 0) @(negedge clock);
            if (!mute && prev_mute) rise_cnt++;
            prev_mute = mute;
            if (!mute) unm[io_ctrl]++;
            if (done) done_cnt++;
            if (io_ctrl == 4'd2) c2_cnt++;
            foreach (vecs[j]) begin
                if (vecs[j].scen == s && vecs[j].k == k) begin
                    chk($sformatf("s%0d_k%0d_io_ctrl", s, k), io_ctrl, vecs[j].ctrl);
                    chk($sformatf("s%0d_k%0d_mute", s, k), mute, vecs[j].mute);
                    chk($sformatf("s%0d_k%0d_busy", s, k), busy, vecs[j].busy);
                    chk($sformatf("s%0d_k%0d_done", s, k), done, vecs[j].done);
                    chk($sformatf("s%0d_k%0d_cur_index", s, k), cur_index, vecs[j].idx);
                end
            end
            if (k == abort_k - 1) abort = 1'b1;
            if (k == abort_k) abort = 1'b0;
            if (k == poke_k) begin
                chk("cfg_ready_while_busy", cfg_ready, 0);
                cfg_valid   = 1'b1;
                cfg_addr    = 3'd0;
                cfg_ctrl    = 4'd9;
                cfg_dwell   = 16'd3;
                start       = 1'b1;
                num_entries = 4'd0;
            end
            if (k == poke_k + 1) begin
                cfg_valid = 1'b0;
                start     = 1'b0;
            end
        end
    endtask

    initial begin
        // {scen, k, io_ctrl, mute, busy, done, cur_index}
        add(1, 0, 0, 1, 1, 0, 0);    add(1, 1, 1, 1, 1, 0, 0);
        add(1, 4, 1, 1, 1, 0, 0);    add(1, 5, 1, 0, 1, 0, 0);
        add(1, 516, 1, 0, 1, 0, 0);  add(1, 517, 2, 1, 1, 0, 1);
        add(1, 521, 2, 0, 1, 0, 1);  add(1, 1549, 4, 1, 1, 0, 3);
        add(1, 2064, 4, 0, 1, 0, 3); add(1, 2065, 4, 1, 1, 1, 3);
        add(1, 2066, 4, 1, 0, 0, 3);
        add(2, 0, 4, 1, 1, 0, 0);    add(2, 1, 5, 1, 1, 0, 0);
        add(2, 5, 5, 0, 1, 0, 0);    add(2, 14, 5, 0, 1, 0, 0);
        add(2, 15, 5, 0, 1, 0, 1);   add(2, 24, 5, 0, 1, 0, 1);
        add(2, 25, 5, 1, 1, 1, 1);   add(2, 26, 5, 1, 0, 0, 1);
        add(3, 0, 5, 1, 1, 0, 0);    add(3, 1, 1, 1, 1, 0, 0);
        add(3, 5, 1, 0, 1, 0, 0);    add(3, 12, 1, 0, 1, 0, 0);
        add(3, 13, 1, 1, 1, 0, 2);   add(3, 14, 3, 1, 1, 0, 2);
        add(3, 18, 3, 0, 1, 0, 2);   add(3, 25, 3, 0, 1, 0, 2);
        add(3, 26, 3, 1, 1, 1, 2);   add(3, 27, 3, 1, 0, 0, 2);
        add(4, 0, 3, 1, 1, 0, 0);    add(4, 1, 1, 1, 1, 0, 0);
        add(4, 5, 1, 0, 1, 0, 0);    add(4, 10, 1, 0, 1, 0, 0);
        add(4, 11, 2, 1, 1, 0, 1);   add(4, 15, 2, 0, 1, 0, 1);
        add(4, 20, 2, 0, 1, 0, 1);   add(4, 21, 1, 1, 1, 0, 0);
        add(4, 25, 1, 0, 1, 0, 0);   add(4, 29, 1, 0, 1, 0, 0);
        add(4, 30, 0, 1, 1, 0, 0);   add(4, 33, 0, 1, 1, 0, 0);
        add(4, 34, 0, 1, 0, 0, 0);   add(4, 36, 0, 1, 0, 0, 0);
        add(5, 0, 0, 1, 1, 0, 0);    add(5, 1, 1, 1, 1, 0, 0);
        add(5, 5, 1, 0, 1, 0, 0);    add(5, 7, 1, 0, 1, 0, 0);
        add(5, 10, 1, 0, 1, 0, 0);   add(5, 11, 2, 1, 1, 0, 1);
        add(5, 20, 2, 0, 1, 0, 1);   add(5, 21, 2, 1, 1, 1, 1);
        add(5, 22, 2, 1, 0, 0, 1);
        add(6, 0, 2, 1, 1, 0, 0);    add(6, 1, 1, 1, 1, 0, 0);
        add(6, 8, 1, 0, 1, 0, 0);    add(6, 10, 1, 0, 1, 0, 0);
        add(6, 11, 2, 1, 1, 0, 1);   add(6, 22, 2, 1, 0, 0, 1);
        add(7, 0, 2, 1, 1, 1, 0);    add(7, 1, 2, 1, 0, 0, 0);
        add(8, 6, 1, 0, 1, 0, 0);
        add(9, 0, 0, 1, 1, 0, 0);    add(9, 7, 0, 1, 1, 0, 7);
        add(9, 8, 0, 1, 1, 1, 7);    add(9, 9, 0, 1, 0, 0, 7);

        reset = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_ctrl = '0; cfg_dwell = '0;
        num_entries = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_io_ctrl", io_ctrl, 0);
        chk("rst_mute", mute, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cur_index", cur_index, 0);
        chk("rst_cfg_ready", cfg_ready, 1);

        // Four distinct modes, 512 cycles each.
        for (int i = 0; i < 4; i++) write_entry(i, i + 1, 512);
        pulse_start(4, 1'b0);
        run_vectors(1, 2067, -1, -1);
        for (int i = 1; i <= 4; i++) chk($sformatf("s1_unmuted_ctrl%0d", i), unm[i], 512);
        chk("s1_done_pulses", done_cnt, 1);
        chk("s1_unmute_starts", rise_cnt, 4);

        // Same mode twice: one guard, 20 contiguous unmuted cycles.
        write_entry(0, 5, 10);
        write_entry(1, 5, 10);
        pulse_start(2, 1'b0);
        run_vectors(2, 27, -1, -1);
        chk("s2_unmuted_ctrl5", unm[5], 20);
        chk("s2_unmute_starts", rise_cnt, 1);
        chk("s2_done_pulses", done_cnt, 1);

        // Zero-dwell middle entry is skipped.
        write_entry(0, 1, 8);
        write_entry(1, 2, 0);
        write_entry(2, 3, 8);
        pulse_start(3, 1'b0);
        run_vectors(3, 28, -1, -1);
        chk("s3_ctrl2_cycles", c2_cnt, 0);
        chk("s3_unmuted_ctrl1", unm[1], 8);
        chk("s3_unmuted_ctrl3", unm[3], 8);

        // Looping two entries, aborted mid-run.
        write_entry(0, 1, 6);
        write_entry(1, 2, 6);
        pulse_start(2, 1'b1);
        run_vectors(4, 36, 30, -1);
        chk("s4_done_pulses", done_cnt, 0);
        chk("s4_unmuted_ctrl1", unm[1], 11);
        chk("s4_unmuted_ctrl2", unm[2], 6);
        chk("s4_unmute_starts", rise_cnt, 3);

        // Config write and start while busy are both ignored; replay proves table intact.
        pulse_start(2, 1'b0);
        run_vectors(5, 22, -1, 6);
        chk("s5_done_pulses", done_cnt, 1);
        pulse_start(2, 1'b0);
        run_vectors(6, 22, -1, -1);
        chk("s6_unmuted_ctrl1", unm[1], 6);
        chk("s6_unmuted_ctrl9", unm[9], 0);

        // Zero entries: immediate done, io_ctrl held.
        pulse_start(0, 1'b0);
        run_vectors(7, 1, -1, -1);

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; num_entries = 4'd2; loop_en = 1'b0;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_cfg_ready", cfg_ready, 1);
        @(negedge clock);
        chk("start_abort_busy_later", busy, 0);

        // Reset in the middle of RUN.
        pulse_start(2, 1'b0);
        run_vectors(8, 7, -1, -1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_io_ctrl", io_ctrl, 0);
        chk("midrst_mute", mute, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cur_index", cur_index, 0);
        chk("midrst_cfg_ready", cfg_ready, 1);
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done || busy) done_cnt++;
        end
        chk("midrst_quiet_after", done_cnt, 0);

        // All-zero table, looping, num_entries above DEPTH: one pass then done.
        for (int i = 0; i < 8; i++) write_entry(i, i, 0);
        pulse_start(12, 1'b1);
        run_vectors(9, 10, -1, -1);
        chk("s9_done_pulses", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
